// File: rtl/kswitch_sched_if.sv
// rtl/kswitch_sched_if.sv - requester / switch-FSM signal bundle for kswitch_sched
interface kswitch_sched_if #(
  parameter int NREQ  = 2,
  parameter int CNT_W = 8
);
  logic [NREQ-1:0]  req;
  logic [CNT_W-1:0] on_len;
  logic [CNT_W-1:0] off_len;
  logic             K2;
  logic             K1;
  logic             A;
  logic [NREQ-1:0]  grant;
  logic             busy;
  logic             done;
  logic             err;

  modport master (
    output req, on_len, off_len, K2, K1,
    input  A, grant, busy, done, err
  );

  modport slave (
    input  req, on_len, off_len, K2, K1,
    output A, grant, busy, done, err
  );
endinterface

// File: rtl/kswitch_sched.sv
// rtl/kswitch_sched.sv - round-robin scheduler driving the K2/K1 switch FSM handshake
module kswitch_sched #(
  parameter int NREQ    = 2,
  parameter int CNT_W   = 8,
  parameter int TIMEOUT = 64
) (
  input  logic          Clock,
  input  logic          Reset,
  kswitch_sched_if.slave bus
);
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int WW = CNT_W + 2;
  localparam logic [WW-1:0] WAIT_LAST = WW'(TIMEOUT - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_STOP  = 3'd2;
  localparam logic [2:0] S_CLR   = 3'd3;
  localparam logic [2:0] S_RET   = 3'd4;

  logic [2:0]       state;
  logic [PW-1:0]    rr_ptr;
  logic [CNT_W-1:0] cnt;
  logic [WW-1:0]    wcnt;
  logic [CNT_W-1:0] len_on;
  logic [CNT_W-1:0] len_off;
  logic             a_q;
  logic [NREQ-1:0]  grant_q;
  logic             busy_q;
  logic             done_q;
  logic             err_q;

  logic [2*NREQ-1:0] dbl;
  logic [NREQ-1:0]   rot;
  logic              any;
  logic [PW-1:0]     off;
  logic [PW:0]       sum;
  logic [PW-1:0]     win;
  logic [PW-1:0]     ptr_nxt;
  logic              wait_expired;

  // Rotate requests so rr_ptr sits at bit 0, take the lowest set bit, rotate back.
  always_comb begin
    dbl = {bus.req, bus.req};
    rot = NREQ'(dbl >> rr_ptr);
    any = 1'b0;
    off = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (rot[i]) begin
        any = 1'b1;
        off = PW'(i);
      end
    end
    sum = {1'b0, rr_ptr} + {1'b0, off};
    if (sum >= (PW+1)'(NREQ))
      sum = sum - (PW+1)'(NREQ);
    win     = sum[PW-1:0];
    ptr_nxt = (win == PW'(NREQ - 1)) ? '0 : win + 1'b1;
    wait_expired = (wcnt >= WAIT_LAST);
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state   <= S_IDLE;
      rr_ptr  <= '0;
      cnt     <= '0;
      wcnt    <= '0;
      len_on  <= '0;
      len_off <= '0;
      a_q     <= 1'b0;
      grant_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state)
        S_IDLE: begin
          a_q  <= 1'b0;
          wcnt <= '0;
          if (any) begin
            grant_q <= NREQ'(1) << win;
            busy_q  <= 1'b1;
            len_on  <= (bus.on_len  == '0) ? CNT_W'(1) : bus.on_len;
            len_off <= (bus.off_len == '0) ? CNT_W'(1) : bus.off_len;
            a_q     <= 1'b1;
            cnt     <= CNT_W'(1);
            rr_ptr  <= ptr_nxt;
            state   <= S_START;
          end
        end
        // The grant cycle already counts as the first A-high cycle.
        S_START: begin
          if (cnt >= len_on) begin
            a_q   <= 1'b0;
            cnt   <= CNT_W'(1);
            state <= S_STOP;
          end else if (cnt != '1) begin
            cnt <= cnt + 1'b1;
          end
        end
        S_STOP: begin
          if (cnt >= len_off) begin
            a_q   <= 1'b1;
            wcnt  <= '0;
            state <= S_CLR;
          end else if (cnt != '1) begin
            cnt <= cnt + 1'b1;
          end
        end
        S_CLR: begin
          if (bus.K2) begin
            a_q   <= 1'b0;
            wcnt  <= '0;
            state <= S_RET;
          end else if (wait_expired) begin
            err_q   <= 1'b1;
            a_q     <= 1'b0;
            grant_q <= '0;
            busy_q  <= 1'b0;
            wcnt    <= '0;
            state   <= S_IDLE;
          end else begin
            wcnt <= wcnt + 1'b1;
          end
        end
        S_RET: begin
          if (bus.K1) begin
            done_q  <= 1'b1;
            grant_q <= '0;
            busy_q  <= 1'b0;
            state   <= S_IDLE;
          end else if (wait_expired) begin
            err_q   <= 1'b1;
            a_q     <= 1'b0;
            grant_q <= '0;
            busy_q  <= 1'b0;
            wcnt    <= '0;
            state   <= S_IDLE;
          end else begin
            wcnt <= wcnt + 1'b1;
          end
        end
        default: begin
          a_q     <= 1'b0;
          grant_q <= '0;
          busy_q  <= 1'b0;
          state   <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.A     = a_q;
  assign bus.grant = grant_q;
  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
  assign bus.err   = err_q;
endmodule

// File: tb/tb_kswitch_sched.sv
// tb/tb_kswitch_sched.sv - self-checking bench for kswitch_sched
module tb_kswitch_sched;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  kswitch_sched_if #(.NREQ(2), .CNT_W(8)) bus ();

  kswitch_sched #(.NREQ(2), .CNT_W(8), .TIMEOUT(64)) dut (
    .Clock (clk),
    .Reset (rst),
    .bus   (bus)
  );

  // Switch FSM model: K2 after A has been high two sampled cycles, K1 after two low.
  bit model_en = 1'b1;
  int hi_run = 0;
  int lo_run = 0;
  always @(posedge clk) begin
    hi_run <= (bus.A === 1'b1) ? hi_run + 1 : 0;
    lo_run <= (bus.A === 1'b0) ? lo_run + 1 : 0;
  end
  always @(negedge clk) begin
    bus.K2 = model_en && (hi_run >= 2);
    bus.K1 = model_en && (lo_run >= 2);
  end

  typedef struct {
    logic [1:0] req;
    logic [7:0] on_len;
    logic [7:0] off_len;
    bit         model;
    int         g;
    int         hi;
    int         lo;
    int         chi;
    int         nd;
    int         ne;
  } vec_t;

  vec_t tbl[6];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Starts at a negedge; returns measured dwell lengths and pulse counts.
  task automatic run_seq(input logic [1:0] r, input logic [7:0] on, input logic [7:0] off,
                         output int g, output int hi, output int lo, output int chi,
                         output int nd, output int ne, output int idle_bad, output int both);
    bus.req = r;
    bus.on_len = on;
    bus.off_len = off;
    @(negedge clk);
    g = int'(bus.grant);
    bus.req = 2'b00;
    bus.on_len = 8'hff;
    bus.off_len = 8'hff;
    hi = 0; lo = 0; chi = 0; nd = 0; ne = 0; idle_bad = 0; both = 0;
    while (bus.A === 1'b1 && hi < 300) begin hi++; @(negedge clk); end
    while (bus.A === 1'b0 && lo < 300) begin lo++; @(negedge clk); end
    while (bus.A === 1'b1 && chi < 300) begin chi++; @(negedge clk); end
    for (int k = 0; k < 300; k++) begin
      if (bus.done === 1'b1) nd++;
      if (bus.err === 1'b1) ne++;
      if (bus.done === 1'b1 && bus.err === 1'b1) both++;
      if (bus.busy !== 1'b1) break;
      @(negedge clk);
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (bus.done === 1'b1) nd++;
      if (bus.err === 1'b1) ne++;
      if (bus.grant !== 2'b00 || bus.busy !== 1'b0 || bus.A !== 1'b0) idle_bad++;
    end
  endtask

  initial begin
    int g, hi, lo, chi, nd, ne, idle_bad, both;
    int ng, ndone, gap_bad, waited;
    logic [1:0] prev;
    logic [1:0] gseq[4];

    tbl[0] = '{req: 2'b01, on_len: 8'd3, off_len: 8'd2, model: 1'b1, g: 1, hi: 3, lo: 2, chi: 3,  nd: 1, ne: 0};
    tbl[1] = '{req: 2'b11, on_len: 8'd1, off_len: 8'd4, model: 1'b1, g: 2, hi: 1, lo: 4, chi: 3,  nd: 1, ne: 0};
    tbl[2] = '{req: 2'b10, on_len: 8'd0, off_len: 8'd0, model: 1'b1, g: 2, hi: 1, lo: 1, chi: 3,  nd: 1, ne: 0};
    tbl[3] = '{req: 2'b01, on_len: 8'd2, off_len: 8'd1, model: 1'b0, g: 1, hi: 2, lo: 1, chi: 64, nd: 0, ne: 1};
    tbl[4] = '{req: 2'b01, on_len: 8'd5, off_len: 8'd3, model: 1'b1, g: 1, hi: 5, lo: 3, chi: 3,  nd: 1, ne: 0};
    tbl[5] = '{req: 2'b11, on_len: 8'd2, off_len: 8'd2, model: 1'b1, g: 2, hi: 2, lo: 2, chi: 3,  nd: 1, ne: 0};

    bus.req = 2'b00;
    bus.on_len = 8'd0;
    bus.off_len = 8'd0;
    repeat (3) @(negedge clk);
    check("reset A", int'(bus.A), 0);
    check("reset grant", int'(bus.grant), 0);
    check("reset busy", int'(bus.busy), 0);
    check("reset done/err", int'({bus.done, bus.err}), 0);
    rst = 1'b0;
    @(negedge clk);
    check("idle no req", int'({bus.A, bus.grant, bus.busy}), 0);

    for (int i = 0; i < 6; i++) begin
      model_en = tbl[i].model;
      run_seq(tbl[i].req, tbl[i].on_len, tbl[i].off_len, g, hi, lo, chi, nd, ne, idle_bad, both);
      check($sformatf("v%0d grant", i), g, tbl[i].g);
      check($sformatf("v%0d on dwell", i), hi, tbl[i].hi);
      check($sformatf("v%0d off dwell", i), lo, tbl[i].lo);
      check($sformatf("v%0d clr high", i), chi, tbl[i].chi);
      check($sformatf("v%0d done count", i), nd, tbl[i].nd);
      check($sformatf("v%0d err count", i), ne, tbl[i].ne);
      check($sformatf("v%0d stays idle", i), idle_bad, 0);
      check($sformatf("v%0d done&err", i), both, 0);
    end

    // Round-robin with both requesting continuously; rr_ptr is 0 here.
    model_en = 1'b1;
    bus.on_len = 8'd1;
    bus.off_len = 8'd1;
    bus.req = 2'b11;
    ng = 0; ndone = 0; gap_bad = 0; prev = 2'b00;
    for (int c = 0; c < 400 && ndone < 3; c++) begin
      @(negedge clk);
      if (bus.grant != 2'b00 && prev != 2'b00 && bus.grant != prev) gap_bad++;
      if (bus.grant != 2'b00 && prev == 2'b00 && ng < 4) begin gseq[ng] = bus.grant; ng++; end
      if (bus.done === 1'b1) ndone++;
      prev = bus.grant;
    end
    bus.req = 2'b00;
    check("rr grant count", ng, 3);
    check("rr grant0", int'(gseq[0]), 1);
    check("rr grant1", int'(gseq[1]), 2);
    check("rr grant2", int'(gseq[2]), 1);
    check("rr done count", ndone, 3);
    check("rr idle gap", gap_bad, 0);

    // Reset during S_STOP; rr_ptr is 1 before the reset and must return to 0.
    repeat (3) @(negedge clk);
    bus.req = 2'b01;
    bus.on_len = 8'd2;
    bus.off_len = 8'd8;
    @(negedge clk);
    bus.req = 2'b00;
    waited = 0;
    while (bus.A === 1'b1 && waited < 50) begin waited++; @(negedge clk); end
    repeat (2) @(negedge clk);
    check("pre-reset busy", int'(bus.busy), 1);
    #2 rst = 1'b1;
    #1;
    check("async reset outputs", int'({bus.A, bus.grant, bus.busy, bus.done, bus.err}), 0);
    @(negedge clk);
    check("held reset done/err", int'({bus.done, bus.err}), 0);
    rst = 1'b0;
    bus.req = 2'b11;
    bus.on_len = 8'd1;
    bus.off_len = 8'd1;
    @(negedge clk);
    check("post-reset grant", int'(bus.grant), 1);
    bus.req = 2'b00;
    waited = 0;
    while (bus.done !== 1'b1 && waited < 200) begin waited++; @(negedge clk); end
    check("post-reset done", int'(bus.done), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
